// File: rtl/alu16_seq_pkg.sv
// Shared CPU definitions used by the 16-bit ALU sequencer and the 8-bit ALU.
// It holds the ALU opcodes, the ALU size codes, the ZNHC flag bit indices and
// the 16-bit request opcodes. It also has a helper that builds the final
// 16-bit flag word from the per-byte flag results.
package alu16_seq_pkg;

    // 8-bit ALU opcodes
    localparam logic [4:0] ALU_PASS0 = 5'd0;
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_ADC   = 5'd2;
    localparam logic [4:0] ALU_SUB   = 5'd3;
    localparam logic [4:0] ALU_SBC   = 5'd4;

    // ALU size codes: these select how the ALU forms Z
    localparam logic [1:0] ALU_SIZE_8    = 2'd0;
    localparam logic [1:0] ALU_SIZE_16   = 2'd1;
    localparam logic [1:0] ALU_SIZE_SPEC = 2'd2;

    // Flag bit positions within a ZNHC nibble
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    // 16-bit request opcodes
    typedef enum logic [1:0] {
        ALU16_ADD   = 2'd0,
        ALU16_INC   = 2'd1,
        ALU16_DEC   = 2'd2,
        ALU16_ADDSP = 2'd3
    } alu16_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // Final ZNHC of a 16-bit op.
    // ADD16 keeps Z and takes H/C from the high byte.
    // INC/DEC leave the flags alone.
    // ADDSP takes H/C from the low byte.
    function automatic logic [3:0] final_flags(
        input alu16_op_e  op,
        input logic [3:0] req_f,
        input logic [3:0] lo_f,
        input logic [3:0] hi_f
    );
        logic [3:0] f;
        case (op)
            ALU16_ADD:   f = {req_f[FLAG_Z], 1'b0, hi_f[FLAG_H], hi_f[FLAG_C]};
            ALU16_INC:   f = req_f;
            ALU16_DEC:   f = req_f;
            ALU16_ADDSP: f = {1'b0, 1'b0, lo_f[FLAG_H], lo_f[FLAG_C]};
            default:     f = req_f;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu16_seq_if.sv
// Bus between the CPU control unit / shared ALU and the 16-bit sequencer.
//   req_*        : 16-bit operation request with valid/ready handshake
//   alu_*        : byte-op drive to the ALU and its combinational results
//   rsp_*        : one-cycle response pulse with held data/flags
// The slave modport is the sequencer. The master modport is the CPU/ALU side.
interface alu16_seq_if;
    import alu16_seq_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_flags;

    logic [4:0]  alu_op;
    logic [1:0]  alu_size;
    logic [7:0]  alu_data0;
    logic [7:0]  alu_data1;
    logic [3:0]  alu_flags;
    logic [7:0]  alu_result;
    logic [3:0]  alu_flags_res;
    logic        alu_busy;

    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_flags,
        output req_ready,
        output alu_op, alu_size, alu_data0, alu_data1, alu_flags, alu_busy,
        input  alu_result, alu_flags_res,
        output rsp_valid, rsp_data, rsp_flags
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_flags,
        input  req_ready,
        input  alu_op, alu_size, alu_data0, alu_data1, alu_flags, alu_busy,
        output alu_result, alu_flags_res,
        input  rsp_valid, rsp_data, rsp_flags
    );
endinterface

// File: rtl/alu.sv
// 8-bit CPU ALU: purely combinational. It returns the result and the ZNHC flags.
//   op/size      : ALU opcode and size code
//   data0/data1  : addend or subtrahend / base operand
//   flags        : incoming ZNHC; C feeds ADC/SBC
//   result       : 8-bit result
//   flags_res    : outgoing ZNHC
// H is the carry or borrow out of bit 3, and C is the carry or borrow out of bit 7.
// Z comes from the result for SIZE_8. SIZE_16 passes the incoming Z through.
// SPEC clears Z.
module alu
    import alu16_seq_pkg::*;
(
    input  logic [4:0] op,
    input  logic [1:0] size,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [3:0] flags,
    output logic [7:0] result,
    output logic [3:0] flags_res
);
    logic [8:0] full_s;
    logic [4:0] half_s;
    logic       cin_s;
    logic       zero_s;

    // Byte arithmetic with nibble and byte carries
    always_comb begin
        full_s    = 9'd0;
        half_s    = 5'd0;
        cin_s     = 1'b0;
        zero_s    = 1'b0;
        result    = data0;
        flags_res = flags;
        case (op)
            ALU_ADD, ALU_ADC: begin
                cin_s     = (op == ALU_ADC) ? flags[FLAG_C] : 1'b0;
                half_s    = {1'b0, data1[3:0]} + {1'b0, data0[3:0]} + {4'd0, cin_s};
                full_s    = {1'b0, data1} + {1'b0, data0} + {8'd0, cin_s};
                result    = full_s[7:0];
                flags_res = {1'b0, 1'b0, half_s[4], full_s[8]};
            end
            ALU_SUB, ALU_SBC: begin
                cin_s     = (op == ALU_SBC) ? flags[FLAG_C] : 1'b0;
                half_s    = {1'b0, data1[3:0]} - {1'b0, data0[3:0]} - {4'd0, cin_s};
                full_s    = {1'b0, data1} - {1'b0, data0} - {8'd0, cin_s};
                result    = full_s[7:0];
                flags_res = {1'b0, 1'b1, half_s[4], full_s[8]};
            end
            default: begin
                result    = data0;
                flags_res = flags;
            end
        endcase
        zero_s = (result == 8'h00);
        if (op != ALU_PASS0) begin
            case (size)
                ALU_SIZE_8:    flags_res[FLAG_Z] = zero_s;
                ALU_SIZE_16:   flags_res[FLAG_Z] = flags[FLAG_Z];
                ALU_SIZE_SPEC: flags_res[FLAG_Z] = 1'b0;
                default:       flags_res[FLAG_Z] = zero_s;
            endcase
        end else begin
            flags_res[FLAG_Z] = flags[FLAG_Z];
        end
    end
endmodule

// File: rtl/alu16_seq.sv
// 16-bit arithmetic sequencer. It runs ADD16 / INC16 / DEC16 / ADDSP as two byte
// ops on the shared 8-bit ALU: first the low byte, then the high byte with
// the carry chained.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : alu16_seq_if slave (request, ALU drive/results, response)
// The ALU drive is a combinational decode of the state and the latched operands.
// The response registers load on the HIGH->DONE edge. They then hold until the
// next op reaches DONE.
module alu16_seq
    import alu16_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu16_seq_if.slave  bus
);
    seq_state_e  state_r, next_state_s;
    alu16_op_e   op_r;
    logic [15:0] a_r, b_r;
    logic [3:0]  flags_r;
    logic [7:0]  res_lo_r;
    logic [3:0]  flags_lo_r;
    logic        rsp_valid_r;
    logic [15:0] rsp_data_r;
    logic [3:0]  rsp_flags_r;

    logic [4:0]  alu_op_s;
    logic [1:0]  alu_size_s;
    logic [7:0]  alu_data0_s, alu_data1_s;
    logic [3:0]  alu_flags_s;
    logic        req_ready_s, alu_busy_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: a fixed four-cycle walk once a request is accepted
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: next_state_s = bus.req_valid ? ST_LOW : ST_IDLE;
            ST_LOW:  next_state_s = ST_HIGH;
            ST_HIGH: next_state_s = ST_DONE;
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Operand latch, low-byte capture and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r        <= ALU16_ADD;
            a_r         <= 16'h0000;
            b_r         <= 16'h0000;
            flags_r     <= 4'h0;
            res_lo_r    <= 8'h00;
            flags_lo_r  <= 4'h0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 16'h0000;
            rsp_flags_r <= 4'h0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_r    <= alu16_op_e'(bus.req_op);
                        a_r     <= bus.req_a;
                        b_r     <= bus.req_b;
                        flags_r <= bus.req_flags;
                    end
                end
                ST_LOW: begin
                    res_lo_r   <= bus.alu_result;
                    flags_lo_r <= bus.alu_flags_res;
                end
                ST_HIGH: begin
                    // The high byte result goes directly into the response
                    // register, so the response is ready in DONE.
                    rsp_valid_r <= 1'b1;
                    rsp_data_r  <= {bus.alu_result, res_lo_r};
                    rsp_flags_r <= final_flags(op_r, flags_r, flags_lo_r, bus.alu_flags_res);
                end
                ST_DONE: begin
                    rsp_valid_r <= 1'b0;
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // ALU drive and handshake outputs decoded from state and latched operands
    always_comb begin
        alu_op_s    = ALU_PASS0;
        alu_size_s  = ALU_SIZE_8;
        alu_data0_s = 8'h00;
        alu_data1_s = 8'h00;
        alu_flags_s = 4'h0;
        req_ready_s = (state_r == ST_IDLE);
        alu_busy_s  = (state_r == ST_LOW) || (state_r == ST_HIGH);
        case (state_r)
            ST_LOW: begin
                alu_data1_s = a_r[7:0];
                alu_flags_s = flags_r;
                case (op_r)
                    ALU16_ADD:   begin alu_op_s = ALU_ADD; alu_size_s = ALU_SIZE_16;   alu_data0_s = b_r[7:0]; end
                    ALU16_INC:   begin alu_op_s = ALU_ADD; alu_size_s = ALU_SIZE_16;   alu_data0_s = 8'h01;    end
                    ALU16_DEC:   begin alu_op_s = ALU_SUB; alu_size_s = ALU_SIZE_16;   alu_data0_s = 8'h01;    end
                    ALU16_ADDSP: begin alu_op_s = ALU_ADD; alu_size_s = ALU_SIZE_SPEC; alu_data0_s = b_r[7:0]; end
                    default:     begin alu_op_s = ALU_PASS0; alu_data0_s = 8'h00; end
                endcase
            end
            ST_HIGH: begin
                alu_data1_s = a_r[15:8];
                alu_flags_s = {flags_r[FLAG_Z], flags_r[FLAG_N], flags_r[FLAG_H], flags_lo_r[FLAG_C]};
                case (op_r)
                    ALU16_ADD:   begin alu_op_s = ALU_ADC; alu_size_s = ALU_SIZE_16;   alu_data0_s = b_r[15:8];  end
                    ALU16_INC:   begin alu_op_s = ALU_ADC; alu_size_s = ALU_SIZE_16;   alu_data0_s = 8'h00;      end
                    ALU16_DEC:   begin alu_op_s = ALU_SBC; alu_size_s = ALU_SIZE_16;   alu_data0_s = 8'h00;      end
                    // Sign-extend e into the high byte
                    ALU16_ADDSP: begin alu_op_s = ALU_ADC; alu_size_s = ALU_SIZE_SPEC; alu_data0_s = {8{b_r[7]}}; end
                    default:     begin alu_op_s = ALU_PASS0; alu_data0_s = 8'h00; end
                endcase
            end
            ST_IDLE: begin
                alu_op_s = ALU_PASS0;
            end
            ST_DONE: begin
                alu_op_s = ALU_PASS0;
            end
            default: begin
                alu_op_s = ALU_PASS0;
            end
        endcase
    end

    assign bus.req_ready = req_ready_s;
    assign bus.alu_busy  = alu_busy_s;
    assign bus.alu_op    = alu_op_s;
    assign bus.alu_size  = alu_size_s;
    assign bus.alu_data0 = alu_data0_s;
    assign bus.alu_data1 = alu_data1_s;
    assign bus.alu_flags = alu_flags_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_flags = rsp_flags_r;
endmodule

// File: tb/tb_alu16_seq.sv
// Self-checking bench for alu16_seq with the 8-bit alu beside it.
// The expected results come from a plain 16-bit arithmetic reference model.
module tb_alu16_seq;
    import alu16_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors_cnt = 0;
    int   checks_cnt = 0;

    alu16_seq_if bus();

    alu16_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    alu u_alu (
        .op        (bus.alu_op),
        .size      (bus.alu_size),
        .data0     (bus.alu_data0),
        .data1     (bus.alu_data1),
        .flags     (bus.alu_flags),
        .result    (bus.alu_result),
        .flags_res (bus.alu_flags_res)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: whole 16-bit values with integer arithmetic
    task automatic ref_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] f, output logic [15:0] d, output logic [3:0] fo);
        int ai, bi, sum, e;
        ai = int'(a);
        bi = int'(b);
        case (op)
            2'd0: begin
                sum = ai + bi;
                d   = 16'(sum % 65536);
                fo  = {f[3], 1'b0, ((ai % 4096) + (bi % 4096)) > 4095, sum > 65535};
            end
            2'd1: begin d = 16'((ai + 1) % 65536);     fo = f; end
            2'd2: begin d = 16'((ai + 65535) % 65536); fo = f; end
            default: begin
                e  = (bi % 256 >= 128) ? (bi % 256) - 256 : (bi % 256);
                d  = 16'((ai + e + 65536) % 65536);
                fo = {1'b0, 1'b0, ((ai % 16) + (bi % 16)) > 15, ((ai % 256) + (bi % 256)) > 255};
            end
        endcase
    endtask

    // Issues one op from an IDLE negedge and checks it cycle by cycle.
    // With hold=1, req_valid stays high with junk operands while the
    // sequencer is busy. The junk must be ignored.
    task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f, input logic [15:0] exp_d, input logic [3:0] exp_f,
                         input bit hold);
        check_eq("ready_before_accept", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_flags = f;
        @(posedge clk);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.req_valid = hold;
            bus.req_op    = 2'($urandom);
            bus.req_a     = 16'($urandom);
            bus.req_b     = 16'($urandom);
            bus.req_flags = 4'($urandom);
            check_eq("ready_low_busy", 32'(bus.req_ready), 32'd0);
            check_eq("alu_busy", 32'(bus.alu_busy), 32'(i < 3));
            check_eq("rsp_valid_timing", 32'(bus.rsp_valid), 32'(i == 3));
        end
        check_eq("rsp_data", 32'(bus.rsp_data), 32'(exp_d));
        check_eq("rsp_flags", 32'(bus.rsp_flags), 32'(exp_f));
        @(negedge clk);
        check_eq("rsp_single_pulse", 32'(bus.rsp_valid), 32'd0);
        check_eq("ready_back", 32'(bus.req_ready), 32'd1);
        check_eq("rsp_data_hold", 32'(bus.rsp_data), 32'(exp_d));
        check_eq("rsp_flags_hold", 32'(bus.rsp_flags), 32'(exp_f));
        check_eq("idle_alu_op", 32'(bus.alu_op), 32'(ALU_PASS0));
        check_eq("idle_alu_data0", 32'(bus.alu_data0), 32'd0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [15:0] r_a, r_b, m_d;
        logic [3:0]  r_f, m_f;

        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_a     = 16'h0000;
        bus.req_b     = 16'h0000;
        bus.req_flags = 4'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_busy", 32'(bus.alu_busy), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check_eq("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        check_eq("rst_alu_op", 32'(bus.alu_op), 32'(ALU_PASS0));
        check_eq("rst_alu_size", 32'(bus.alu_size), 32'(ALU_SIZE_8));
        check_eq("rst_alu_data1", 32'(bus.alu_data1), 32'd0);
        check_eq("rst_alu_flags", 32'(bus.alu_flags), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed expectations
        do_op(2'd0, 16'h0FFF, 16'h0001, 4'h8, 16'h1000, 4'b1010, 1'b0);
        do_op(2'd0, 16'hFFFF, 16'h0001, 4'h0, 16'h0000, 4'b0011, 1'b0);
        do_op(2'd1, 16'h00FF, 16'h0000, 4'b0101, 16'h0100, 4'b0101, 1'b0);
        do_op(2'd2, 16'h0000, 16'h0000, 4'b1110, 16'hFFFF, 4'b1110, 1'b0);
        do_op(2'd3, 16'hFFF8, 16'h0008, 4'h0, 16'h0000, 4'b0011, 1'b0);
        do_op(2'd3, 16'h0005, 16'h00FF, 4'h0, 16'h0004, 4'b0011, 1'b0);

        // Randomized ops against the reference model
        repeat (40) begin
            r_op = 2'($urandom);
            r_a  = 16'($urandom);
            r_b  = 16'($urandom);
            r_f  = 4'($urandom);
            ref_model(r_op, r_a, r_b, r_f, m_d, m_f);
            do_op(r_op, r_a, r_b, r_f, m_d, m_f, 1'b0);
        end

        // Back-to-back: valid held high, so one accept every 4 cycles
        for (int k = 0; k < 6; k++) begin
            r_op = 2'($urandom);
            r_a  = 16'($urandom);
            r_b  = 16'($urandom);
            r_f  = 4'($urandom);
            ref_model(r_op, r_a, r_b, r_f, m_d, m_f);
            do_op(r_op, r_a, r_b, r_f, m_d, m_f, 1'b1);
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("stream_stop_ready", 32'(bus.req_ready), 32'd1);

        // Make rsp_data nonzero, then reset in the middle of HIGH
        do_op(2'd0, 16'h1234, 16'h1111, 4'h0, 16'h2345, 4'b0000, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd0;
        bus.req_a     = 16'h00FF;
        bus.req_b     = 16'h0001;
        bus.req_flags = 4'h0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_busy", 32'(bus.alu_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("arst_ready", 32'(bus.req_ready), 32'd1);
        check_eq("arst_busy", 32'(bus.alu_busy), 32'd0);
        check_eq("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("arst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check_eq("arst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        check_eq("arst_alu_op", 32'(bus.alu_op), 32'(ALU_PASS0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check_eq("post_rst_ready", 32'(bus.req_ready), 32'd1);
        end
        do_op(2'd2, 16'h8000, 16'h0000, 4'b0110, 16'h7FFF, 4'b0110, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end
endmodule
